// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: gates the UART frame capture block, checks each frame and buffers bytes for the host
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_ODD = 1'b0,
    parameter bit DROP_BAD   = 1'b1
) (
    input  logic        i_baud_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_active_flag,
    input  logic        i_done_flag,
    input  logic [10:0] i_frame,
    output logic        o_rx_en,
    output logic [7:0]  o_dout,
    output logic        o_dout_err,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    output logic        o_framing_err,
    output logic        o_parity_err,
    output logic        o_overrun_err,
    input  logic        i_err_clr,
    output logic [7:0]  o_frame_cnt,
    output logic        o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_OFF, S_ARMED, S_RECV, S_CHECK} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_frame;
    logic [8:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_framing_err;
    logic        r_parity_err;
    logic        r_overrun_err;
    logic [7:0]  r_frame_cnt;
    logic        w_latch;
    logic        w_check;
    logic        w_fe;
    logic        w_pe;
    logic        w_bad;
    logic        w_want;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;

    assign w_check = (r_state == S_CHECK);
    assign w_fe    = r_frame[0] | ~r_frame[10];
    assign w_pe    = (^r_frame[9:1]) != PARITY_ODD;
    assign w_bad   = w_fe | w_pe;
    assign w_want  = w_check & (~w_bad | ~DROP_BAD);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // a pop in the same cycle never makes room for this write
    assign w_push  = w_want & ~w_full;
    assign w_pop   = i_dout_ready & ~w_empty;

    assign o_dout        = r_mem[r_rd_ptr[AW-1:0]][7:0];
    assign o_dout_err    = r_mem[r_rd_ptr[AW-1:0]][8];
    assign o_dout_valid  = ~w_empty;
    assign o_framing_err = r_framing_err;
    assign o_parity_err  = r_parity_err;
    assign o_overrun_err = r_overrun_err;
    assign o_frame_cnt   = r_frame_cnt;

    // receive state register
    always_ff @(posedge i_baud_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_OFF;
        else          r_state <= w_next;
    end

    // next state, capture enable, busy and frame latch strobe
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        o_rx_en = 1'b0;
        o_busy  = 1'b0;
        case (r_state)
            S_OFF: begin
                if (i_enable) w_next = S_ARMED;
            end
            S_ARMED: begin
                o_rx_en = 1'b1;
                if (i_done_flag) begin
                    w_next  = S_CHECK;
                    w_latch = 1'b1;
                end else if (i_active_flag) begin
                    w_next = S_RECV;
                end else if (!i_enable) begin
                    w_next = S_OFF;
                end
            end
            S_RECV: begin
                o_rx_en = 1'b1;
                o_busy  = 1'b1;
                if (i_done_flag) begin
                    w_next  = S_CHECK;
                    w_latch = 1'b1;
                end
            end
            S_CHECK: begin
                o_rx_en = 1'b1;
                o_busy  = 1'b1;
                w_next  = i_enable ? S_ARMED : S_OFF;
            end
            default: w_next = S_OFF;
        endcase
    end

    // hold the finished frame so the check sees a stable copy
    always_ff @(posedge i_baud_clk or negedge i_reset) begin
        if (!i_reset)     r_frame <= '0;
        else if (w_latch) r_frame <= i_frame;
    end

    // receive FIFO storage and pointers
    always_ff @(posedge i_baud_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {w_bad, r_frame[8:1]};
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // sticky error flags, a new error outranks a clear
    always_ff @(posedge i_baud_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_framing_err <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_framing_err <= (r_framing_err & ~i_err_clr) | (w_check & w_fe);
            r_parity_err  <= (r_parity_err & ~i_err_clr) | (w_check & w_pe);
            r_overrun_err <= (r_overrun_err & ~i_err_clr) | (w_want & w_full);
        end
    end

    // every checked frame counts, kept or dropped
    always_ff @(posedge i_baud_clk or negedge i_reset) begin
        if (!i_reset)     r_frame_cnt <= '0;
        else if (w_check) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: random and directed frames against a queue-based model, three parameter sets
module tb_uart_rx_ctrl;
    localparam int N = 3;
    localparam int DEP  [N] = '{4, 8, 2};
    localparam bit ODD  [N] = '{1'b0, 1'b0, 1'b1};
    localparam bit DROP [N] = '{1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        active = 1'b0;
    logic        done = 1'b0;
    logic        dout_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic [10:0] frame = '0;

    logic        rx_en [N];
    logic [7:0]  dout [N];
    logic        dout_err [N];
    logic        dout_valid [N];
    logic        fe [N];
    logic        pe [N];
    logic        ov [N];
    logic [7:0]  cnt [N];
    logic        busy [N];

    int n_chk = 0;
    int n_fail = 0;
    int ready_mode = 0;

    logic [8:0] exp_q [N][$];
    bit         e_fe [N];
    bit         e_pe [N];
    bit         e_ov [N];
    logic [7:0] e_cnt [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_rx_ctrl #(.FIFO_DEPTH(DEP[g]), .PARITY_ODD(ODD[g]), .DROP_BAD(DROP[g])) u_dut (
            .i_baud_clk(clk), .i_reset(rst_n), .i_enable(enable), .i_active_flag(active),
            .i_done_flag(done), .i_frame(frame), .o_rx_en(rx_en[g]), .o_dout(dout[g]),
            .o_dout_err(dout_err[g]), .o_dout_valid(dout_valid[g]), .i_dout_ready(dout_ready),
            .o_framing_err(fe[g]), .o_parity_err(pe[g]), .o_overrun_err(ov[g]),
            .i_err_clr(err_clr), .o_frame_cnt(cnt[g]), .o_busy(busy[g])
        );
    end

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        dout_ready = (ready_mode == 2) ? 1'b1 : (ready_mode == 1) ? 1'($urandom % 2) : 1'b0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (dout_valid[i]) begin
                n_chk++;
                if (exp_q[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_valid u%0d: got entry %03h, expected no entry", i, {dout_err[i], dout[i]});
                end else if (dout_ready) begin
                    logic [8:0] e;
                    e = exp_q[i].pop_front();
                    n_chk++;
                    if ({dout_err[i], dout[i]} !== e) begin
                        n_fail++;
                        $display("FAIL dout u%0d: got %03h expected %03h", i, {dout_err[i], dout[i]}, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0h expected %0h", name, i, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit odd);
        return {1'b1, (^d) ^ odd, d, 1'b0};
    endfunction

    task automatic model_frame(input logic [10:0] f, input bit clr);
        bit b_fe, b_pe, bad;
        for (int i = 0; i < N; i++) begin
            b_fe = f[0] | ~f[10];
            b_pe = (^f[9:1]) != ODD[i];
            bad  = b_fe | b_pe;
            if (clr) begin
                e_fe[i] = 0;
                e_pe[i] = 0;
                e_ov[i] = 0;
            end
            e_fe[i] |= b_fe;
            e_pe[i] |= b_pe;
            if (!bad || !DROP[i]) begin
                if (exp_q[i].size() < DEP[i]) exp_q[i].push_back({bad, f[8:1]});
                else e_ov[i] = 1;
            end
            e_cnt[i] = e_cnt[i] + 8'd1;
        end
    endtask

    task automatic clear_model_errs();
        for (int i = 0; i < N; i++) begin
            e_fe[i] = 0;
            e_pe[i] = 0;
            e_ov[i] = 0;
        end
    endtask

    task automatic send(input logic [10:0] f, input int n_act, input bit clr);
        if (n_act > 0) begin
            active = 1'b1;
            repeat (n_act) tick();
        end
        frame = f;
        done = 1'b1;
        tick();
        done = 1'b0;
        active = 1'b0;
        frame = 11'($urandom);
        err_clr = clr;
        model_frame(f, clr);
        tick();
        err_clr = 1'b0;
    endtask

    task automatic status();
        for (int i = 0; i < N; i++) begin
            chk("framing_err", i, fe[i], e_fe[i]);
            chk("parity_err", i, pe[i], e_pe[i]);
            chk("overrun_err", i, ov[i], e_ov[i]);
            chk("frame_cnt", i, cnt[i], e_cnt[i]);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        clear_model_errs();
        status();
    endtask

    task automatic drain();
        int t = 0;
        ready_mode = 2;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 100) begin
            tick();
            t++;
        end
        tick();
        ready_mode = 0;
        tick();
        for (int i = 0; i < N; i++) begin
            chk("drain_left", i, exp_q[i].size(), 0);
            chk("drain_valid", i, dout_valid[i], 0);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) e_cnt[i] = 8'd0;
        clear_model_errs();
        repeat (2) tick();
        for (int i = 0; i < N; i++) begin
            chk("rst_rx_en", i, rx_en[i], 0);
            chk("rst_dout", i, {dout_err[i], dout[i]}, 0);
            chk("rst_valid", i, dout_valid[i], 0);
            chk("rst_busy", i, busy[i], 0);
        end
        status();
        rst_n = 1'b1;
        tick();
        chk("off_rx_en", 0, rx_en[0], 0);
        enable = 1'b1;
        tick();
        chk("armed_rx_en", 0, rx_en[0], 1);
        chk("armed_busy", 0, busy[0], 0);

        // good frame and latency
        frame = mk(8'hA5, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        frame = 11'($urandom);
        model_frame(mk(8'hA5, 1'b0), 1'b0);
        chk("lat_not_yet", 0, dout_valid[0], 0);
        chk("check_busy", 0, busy[0], 1);
        tick();
        chk("lat_valid", 0, dout_valid[0], 1);
        chk("lat_dout", 0, dout[0], 8'hA5);
        chk("lat_err", 0, dout_err[0], 0);
        status();
        drain();

        // bad stop bit, dropped in u0, kept with tag in u1
        send({1'b0, 1'b0, 8'hA5, 1'b0}, 0, 1'b0);
        chk("drop_empty", 0, dout_valid[0], 0);
        status();
        pulse_clr();
        drain();

        // parity error kept when not dropping
        send({1'b1, 1'b0, 8'h01, 1'b0}, 1, 1'b0);
        chk("pe_dout", 1, dout[1], 8'h01);
        chk("pe_err", 1, dout_err[1], 1);
        status();
        drain();
        pulse_clr();

        // overrun with host stalled
        for (int k = 0; k < 5; k++) send(mk(8'h10 + 8'(k), 1'b0), k % 2, 1'b0);
        chk("overrun_set", 0, ov[0], 1);
        status();
        drain();
        pulse_clr();

        // enable dropped mid-frame
        active = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        chk("recv_busy", 0, busy[0], 1);
        chk("recv_rx_en", 0, rx_en[0], 1);
        frame = mk(8'h3C, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        active = 1'b0;
        model_frame(mk(8'h3C, 1'b0), 1'b0);
        chk("late_check_busy", 0, busy[0], 1);
        tick();
        chk("late_off_rx_en", 0, rx_en[0], 0);
        chk("late_off_busy", 0, busy[0], 0);
        chk("late_stored", 0, dout[0], 8'h3C);
        status();
        enable = 1'b1;
        tick();
        chk("rearm_rx_en", 0, rx_en[0], 1);
        drain();

        // reset mid-frame with two entries stored
        send(mk(8'h55, 1'b0), 0, 1'b0);
        send(mk(8'h66, 1'b0), 2, 1'b0);
        active = 1'b1;
        tick();
        chk("pre_rst_busy", 0, busy[0], 1);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            e_cnt[i] = 8'd0;
            chk("mid_rst_rx_en", i, rx_en[i], 0);
            chk("mid_rst_dout", i, {dout_err[i], dout[i]}, 0);
            chk("mid_rst_valid", i, dout_valid[i], 0);
            chk("mid_rst_busy", i, busy[i], 0);
        end
        clear_model_errs();
        status();
        active = 1'b0;
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_rx_en", 0, rx_en[0], 0);
        enable = 1'b1;
        tick();
        chk("post_rst_armed", 0, rx_en[0], 1);

        // random traffic, long enough to wrap the frame counter
        ready_mode = 1;
        for (int n = 0; n < 300; n++) begin
            logic [10:0] f;
            f = mk(8'($urandom), 1'($urandom % 2));
            if ($urandom % 5 == 0) f[0] = 1'b1;
            if ($urandom % 5 == 0) f[10] = 1'b0;
            send(f, $urandom % 3, ($urandom % 8) == 0);
            status();
            if ($urandom % 10 == 0) pulse_clr();
            if ($urandom % 12 == 0) begin
                enable = 1'b0;
                tick();
                tick();
                chk("rand_off_rx_en", 0, rx_en[0], 0);
                enable = 1'b1;
                tick();
                chk("rand_on_rx_en", 0, rx_en[0], 1);
            end
        end
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller for the UART serial-in/parallel-out frame capture block.
- Gates the capture block on and off, and latches each completed 11-bit frame.
- Checks start, stop and parity bits, and buffers good bytes in a small FIFO.
- Presents bytes to the host with a valid/ready handshake, and keeps sticky error status and a frame counter for the register interface.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the receive FIFO (power of two, 2..16).
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.
- DROP_BAD, 1, 1 = frames with framing or parity errors are not written to the FIFO; 0 = written with the err tag set.

Ports:
- baud_clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- enable  in  1  host request to receive.
- active_flag  in  1  capture block is shifting a frame.
- done_flag  in  1  capture block finished a frame; treated as a 1-cycle pulse.
- frame  in  11  captured frame; bit0 start, bits8:1 data LSB-first, bit9 parity, bit10 stop.
- rx_en  out  1  enables the capture block.
- dout  out  8  head-of-FIFO data byte.
- dout_err  out  1  head entry had a framing or parity error (always 0 when DROP_BAD=1).
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  host accepts dout this cycle.
- framing_err  out  1  sticky: start!=0 or stop!=1 seen.
- parity_err  out  1  sticky: parity mismatch seen.
- overrun_err  out  1  sticky: frame arrived while FIFO full.
- err_clr  in  1  clears all sticky errors.
- frame_cnt  out  8  count of completed frames, wraps 255->0.
- busy  out  1  state is RECV or CHECK.

Behaviour:
- Reset (reset low, asynchronous):
  - state = OFF; FIFO empty with pointers 0.
  - Outputs: rx_en=0, dout=0, dout_err=0, dout_valid=0, framing_err=0, parity_err=0, overrun_err=0, frame_cnt=0, busy=0.
- States: OFF, ARMED, RECV, CHECK.
  - OFF: rx_en=0. Moves to ARMED when enable=1.
  - ARMED: rx_en=1.
    - Moves to RECV on active_flag=1.
    - On done_flag=1, moves straight to CHECK (covers a missed active_flag); frame is latched.
    - If enable=0 and no frame is in progress, moves to OFF.
  - RECV: rx_en=1; busy=1. On done_flag=1, latches frame into an internal register and moves to CHECK.
    - enable=0 during RECV does not abort; the frame completes first.
  - CHECK: exactly one cycle; busy=1.
    - Evaluates the latched frame; updates errors, frame_cnt and the FIFO write.
    - Moves to ARMED if enable=1, else OFF.
- Checks, all on the latched frame:
  - fe = frame[0] | ~frame[10].
  - pe = (^frame[9:1]) != PARITY_ODD, i.e. even parity requires the XOR of data and parity bits to be 0.
  - fe sets framing_err; pe sets parity_err.
- FIFO write in CHECK:
  - Writes when not full, and either (fe|pe)=0 or DROP_BAD=0.
  - Entry = {fe|pe, frame[8:1]}.
  - If the FIFO is full and the entry would be written: the entry is discarded and overrun_err is set. A concurrent pop in the same cycle does not free space for this write.
- frame_cnt increments in every CHECK cycle, whether the frame is good, bad or dropped.
- Latency: done_flag high on edge N -> CHECK during cycle N+1 -> dout_valid=1 after edge N+2, when the FIFO was empty.
- Pop: on dout_ready & dout_valid, the read pointer advances.
  - dout and dout_err are combinational from the head entry; they hold when dout_valid=0.
  - dout_ready while empty has no effect.
- Simultaneous push and pop:
  - Both occur when the FIFO is not full; the count is unchanged.
  - When empty, the push wins and the pop is ignored.
- Pointers are log2(FIFO_DEPTH)+1 bits with wrap-around; full/empty are derived from the MSB comparison.
- Sticky errors:
  - err_clr=1 clears all three.
  - If a new error is detected in the same cycle as err_clr, set wins.
- Reset mid-frame returns to OFF and clears the FIFO; the next frame is taken only after rx_en re-asserts.

Test Plan:
- Good frame, PARITY_ODD=0, frame=11'b1_0_10100101_0 (data 0xA5, parity 0) with done pulse -> 2 cycles later dout=0xA5, dout_valid=1, dout_err=0, no errors, frame_cnt=1.
- Stop bit 0 (frame=11'b0_0_10100101_0) with DROP_BAD=1 -> framing_err=1, FIFO stays empty, frame_cnt=1; then err_clr -> framing_err=0.
- Parity wrong (data 0x01, parity 0, even) with DROP_BAD=0 -> dout=0x01, dout_err=1, parity_err=1.
- FIFO_DEPTH=4, five good frames with dout_ready=0:
  - First four (0x10..0x13) are stored; the fifth sets overrun_err=1.
  - Draining yields 0x10..0x13 in order, then dout_valid=0.
- enable dropped while active_flag=1 -> frame completes, byte is stored, state goes to OFF, rx_en=0 one cycle after CHECK.
- reset low during RECV with 2 entries stored -> all outputs are at reset values immediately; after release, rx_en=1 only once enable=1.
